// File: rtl/cursor_paint_ctrl.sv
// cursor_paint_ctrl: debounced button cursor mover that paints the cursor footprint into a down-scaled frame buffer
module cursor_paint_ctrl #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int SIZE = 16,
  parameter int STEP = 16,
  parameter int SHIFT = 1,
  parameter int COLOR_W = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES = 0,
  parameter int WRAP = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 up_but,
  input  logic                 down_but,
  input  logic                 left_but,
  input  logic                 right_but,
  input  logic                 pintar_but,
  input  logic [3*COLOR_W-1:0] color_in,
  output logic [10:0]          cursor_x,
  output logic [10:0]          cursor_y,
  output logic                 wr_req,
  output logic [10:0]          wr_x,
  output logic [10:0]          wr_y,
  output logic [3*COLOR_W-1:0] wr_rgb,
  input  logic                 wr_ack,
  output logic                 busy
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
  localparam int BLK = SIZE >> SHIFT;
  localparam int BW = BLK > 1 ? $clog2(BLK) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES > 0 ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
  localparam logic [BW-1:0] B_LAST = BW'(BLK - 1);
  localparam logic [10:0] X_MAX = 11'(H_RES - SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_RES - SIZE);
  localparam logic [10:0] STP = 11'(STEP);
  typedef enum logic [1:0] {IDLE, START, WRITE, DONE} state_t;
  state_t state;
  // bit order {up, down, left, right, paint}, all normalised to 1 = pressed
  logic [4:0] raw, s1, s2, db, flip, rise;
  logic [DW-1:0] dcnt [5];
  logic [RW-1:0] rcnt [4];
  logic [3:0] rep, ev;
  logic [10:0] nx, ny, x0;
  logic [BW-1:0] px, py;
  logic dirty, moved;
  assign raw = {~up_but, ~down_but, ~left_but, ~right_but, pintar_but};
  assign rise = flip & s2;
  assign ev = rise[4:1] | rep;
  assign moved = nx != cursor_x || ny != cursor_y;
  assign busy = state != IDLE;
  for (genvar i = 0; i < 5; i++) begin : g_flip
    assign flip[i] = s2[i] != db[i] && dcnt[i] == D_LAST;
  end
  for (genvar j = 0; j < 4; j++) begin : g_rep
    assign rep[j] = REPEAT_CYCLES > 0 && db[j+1] && rcnt[j] == R_LAST;
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < 5; i++) dcnt[i] <= '0;
      for (int j = 0; j < 4; j++) rcnt[j] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      db <= db ^ flip;
      for (int i = 0; i < 5; i++) dcnt[i] <= (s2[i] == db[i] || flip[i]) ? '0 : dcnt[i] + 1'b1;
      for (int j = 0; j < 4; j++) rcnt[j] <= (!db[j+1] || rep[j]) ? '0 : rcnt[j] + 1'b1;
    end
  end
  // one step per cycle; compares widened so y+STEP cannot overflow
  always_comb begin
    nx = cursor_x;
    ny = cursor_y;
    if (ev[3]) ny = cursor_y < STP ? (WRAP != 0 ? Y_MAX : '0) : cursor_y - STP;
    else if (ev[2]) ny = {1'b0, cursor_y} + {1'b0, STP} > {1'b0, Y_MAX} ? (WRAP != 0 ? '0 : Y_MAX) : cursor_y + STP;
    else if (ev[1]) nx = cursor_x < STP ? (WRAP != 0 ? X_MAX : '0) : cursor_x - STP;
    else if (ev[0]) nx = {1'b0, cursor_x} + {1'b0, STP} > {1'b0, X_MAX} ? (WRAP != 0 ? '0 : X_MAX) : cursor_x + STP;
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cursor_x <= 11'((H_RES - SIZE) / 2);
      cursor_y <= 11'((V_RES - SIZE) / 2);
      wr_req <= 1'b0;
      wr_x <= '0;
      wr_y <= '0;
      wr_rgb <= '0;
      x0 <= '0;
      px <= '0;
      py <= '0;
      dirty <= 1'b0;
    end else begin
      cursor_x <= nx;
      cursor_y <= ny;
      dirty <= moved | rise[0] | (dirty & ~(state == IDLE & db[0]));
      case (state)
        IDLE: if (db[0] && dirty) begin
          state <= START;
          x0 <= cursor_x >> SHIFT;
          wr_x <= cursor_x >> SHIFT;
          wr_y <= cursor_y >> SHIFT;
          wr_rgb <= color_in;
          px <= '0;
          py <= '0;
        end
        START: begin
          state <= WRITE;
          wr_req <= 1'b1;
        end
        WRITE: if (wr_ack) begin
          px <= px == B_LAST ? '0 : px + 1'b1;
          wr_x <= px == B_LAST ? x0 : wr_x + 1'b1;
          if (px == B_LAST) begin
            py <= py + 1'b1;
            wr_y <= wr_y + 1'b1;
          end
          if (px == B_LAST && py == B_LAST) begin
            state <= DONE;
            wr_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cursor_paint_ctrl.sv
// tb_cursor_paint_ctrl: randomized and directed checks of the cursor/paint controller against a queue-based model
module tb_cursor_paint_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1, paint = 1'b0, ack = 1'b0;
  logic u2 = 1'b1, d2 = 1'b1, l2 = 1'b1, r2 = 1'b1;
  logic [23:0] color = 24'hA5C3F0;
  logic [10:0] cx, cy, wx, wy, c2x, c2y, w2x, w2y;
  logic [23:0] rgb, w2rgb;
  logic req, busy, w2req, b2;
  bit ack_rand = 0;
  int tests = 0, fails = 0;
  // model state
  bit [4:0] h1, h2, lvl;
  int run [5];
  int mx, my, phase;
  bit dirty;
  int qx[$], qy[$];
  logic [23:0] mrgb;
  int wxs[$], wys[$], wrgbs[$];

  always #5 clk = ~clk;

  cursor_paint_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .WRAP(1)) dut (
    .CLOCK_50(clk), .reset(rst_n), .up_but(up), .down_but(down), .left_but(left), .right_but(right),
    .pintar_but(paint), .color_in(color), .cursor_x(cx), .cursor_y(cy), .wr_req(req), .wr_x(wx),
    .wr_y(wy), .wr_rgb(rgb), .wr_ack(ack), .busy(busy));

  cursor_paint_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8), .WRAP(0)) dut2 (
    .CLOCK_50(clk), .reset(rst_n), .up_but(u2), .down_but(d2), .left_but(l2), .right_but(r2),
    .pintar_but(1'b0), .color_in(24'h0), .cursor_x(c2x), .cursor_y(c2y), .wr_req(w2req), .wr_x(w2x),
    .wr_y(w2y), .wr_rgb(w2rgb), .wr_ack(1'b0), .busy(b2));

  task automatic chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic mreset();
    h1 = 0; h2 = 0; lvl = 0;
    for (int i = 0; i < 5; i++) run[i] = 0;
    mx = 312; my = 232; phase = 0; dirty = 0;
    qx.delete(); qy.delete();
  endtask

  // phase: 0 idle, 1 start, 2 writing, 3 done
  task automatic mstep();
    bit [4:0] rs = 0;
    int ox = mx, oy = my;
    if (phase == 0) begin
      if (lvl[0] && dirty) begin
        phase = 1; dirty = 0; mrgb = color;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            qx.push_back((mx / 2) + c);
            qy.push_back((my / 2) + r);
          end
      end
    end else if (phase == 1) phase = 2;
    else if (phase == 2) begin
      if (ack) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
        if (qx.size() == 0) phase = 3;
      end
    end else phase = 0;
    for (int i = 0; i < 5; i++)
      if (h2[i] != lvl[i]) begin
        run[i]++;
        if (run[i] == 4) begin
          lvl[i] = h2[i]; run[i] = 0; rs[i] = lvl[i];
        end
      end else run[i] = 0;
    h2 = h1;
    h1 = {~up, ~down, ~left, ~right, paint};
    if (rs[4]) my = my < 16 ? 464 : my - 16;
    else if (rs[3]) my = my + 16 > 464 ? 0 : my + 16;
    else if (rs[2]) mx = mx < 16 ? 624 : mx - 16;
    else if (rs[1]) mx = mx + 16 > 624 ? 0 : mx + 16;
    if (mx != ox || my != oy || rs[0]) dirty = 1;
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) mreset();
    else mstep();

  always @(negedge clk)
    if (rst_n) begin
      chk("cursor_x", cx, mx);
      chk("cursor_y", cy, my);
      chk("busy", busy, phase != 0);
      chk("wr_req", req, phase == 2);
      if (phase == 2 && qx.size() > 0) begin
        chk("wr_x", wx, qx[0]);
        chk("wr_y", wy, qy[0]);
        chk("wr_rgb", rgb, mrgb);
      end
    end

  always @(posedge clk)
    if (rst_n && req && ack) begin
      wxs.push_back(wx);
      wys.push_back(wy);
      wrgbs.push_back(rgb);
    end

  always @(negedge clk) if (ack_rand) ack = 1'($urandom_range(0, 1));

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      0: up = v;
      1: down = v;
      2: left = v;
      3: right = v;
      4: u2 = v;
      5: d2 = v;
      6: l2 = v;
      default: r2 = v;
    endcase
  endtask

  task automatic press(int b);
    set_btn(b, 1'b0); cyc(10);
    set_btn(b, 1'b1); cyc(10);
  endtask

  task automatic hold(int b, int n);
    set_btn(b, 1'b0); cyc(n);
    set_btn(b, 1'b1); cyc(20);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst cursor_x", cx, 312);
    chk("rst cursor_y", cy, 232);
    chk("rst wr_req", req, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_writes(int target, int lim, string n);
    int k = 0;
    while (wxs.size() < target && k < lim) begin cyc(1); k++; end
    chk(n, wxs.size(), target);
  endtask

  task automatic wait_idle(int lim, string n);
    int k = 0;
    while (busy && k < lim) begin cyc(1); k++; end
    chk(n, busy, 0);
  endtask

  task automatic wait_req(int lim, string n);
    int k = 0;
    while (!req && k < lim) begin cyc(1); k++; end
    chk(n, req, 1);
  endtask

  initial begin
    cyc(3);
    chk("reset x", cx, 312);
    chk("reset y", cy, 232);
    chk("reset wr_x", wx, 0);
    chk("reset wr_rgb", rgb, 0);
    rst_n = 1'b1;
    cyc(5);
    // debounced press moves once; short glitch is filtered
    up = 1'b0; cyc(12); up = 1'b1; cyc(12);
    chk("up once y", cy, 216);
    up = 1'b0; cyc(2); up = 1'b1; cyc(12);
    chk("glitch y", cy, 216);
    // left to the edge and wrap
    do_reset();
    repeat (19) press(2);
    chk("19 left x", cx, 8);
    press(2);
    chk("wrap left x", cx, 624);
    press(3);
    chk("wrap right x", cx, 0);
    // single block at reset position, ack always high
    do_reset();
    wxs.delete(); wys.delete(); wrgbs.delete();
    ack = 1'b1; paint = 1'b1;
    wait_writes(64, 300, "blk1 writes");
    wait_idle(20, "blk1 idle");
    for (int k = 0; k < 64 && k < wxs.size(); k++) begin
      chk("blk1 x", wxs[k], 156 + k % 8);
      chk("blk1 y", wys[k], 116 + k / 8);
    end
    if (wrgbs.size() > 0) chk("blk1 rgb", wrgbs[0], 24'hA5C3F0);
    cyc(30);
    chk("no 2nd block", wxs.size(), 64);
    paint = 1'b0; ack = 1'b0;
    cyc(10);
    // stall holds the write, move mid-block causes a second block
    do_reset();
    wxs.delete(); wys.delete(); wrgbs.delete();
    paint = 1'b1;
    wait_req(50, "blk2 req");
    for (int k = 0; k < 5; k++) begin
      chk("stall x", wx, 156);
      chk("stall y", wy, 116);
      chk("stall req", req, 1);
      cyc(1);
    end
    ack_rand = 1;
    press(3);
    wait_writes(128, 3000, "two blocks");
    ack_rand = 0; ack = 1'b0;
    wait_idle(20, "two blocks idle");
    if (wxs.size() >= 128) begin
      chk("blk2 first x", wxs[0], 156);
      chk("blk3 first x", wxs[64], 164);
      chk("blk3 first y", wys[64], 116);
      chk("blk3 last x", wxs[127], 171);
      chk("blk3 last y", wys[127], 123);
    end
    cyc(30);
    chk("no 3rd block", wxs.size(), 128);
    paint = 1'b0;
    cyc(10);
    // async reset mid-block aborts; the next block restarts at cell 0
    do_reset();
    paint = 1'b1;
    wait_req(50, "pre-abort req");
    cyc(3);
    do_reset();
    wxs.delete(); wys.delete();
    ack = 1'b1;
    wait_writes(64, 300, "restart writes");
    if (wxs.size() > 0) chk("restart x", wxs[0], 156);
    paint = 1'b0;
    wait_idle(20, "restart idle");
    ack = 1'b0;
    // randomized buttons, paint, colour and ack
    ack_rand = 1;
    for (int k = 0; k < 150; k++) begin
      up = $urandom_range(0, 2) != 0;
      down = $urandom_range(0, 2) != 0;
      left = $urandom_range(0, 2) != 0;
      right = $urandom_range(0, 2) != 0;
      paint = 1'($urandom_range(0, 1));
      color = 24'($urandom);
      cyc($urandom_range(1, 20));
    end
    up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1; paint = 1'b0;
    cyc(20);
    wait_idle(400, "random idle");
    ack_rand = 0; ack = 1'b0;
    // auto-repeat and clamp on the second instance
    r2 = 1'b0;
    repeat (42) @(posedge clk);
    @(negedge clk);
    r2 = 1'b1;
    cyc(10);
    chk("repeat x", c2x, 408);
    cyc(30);
    chk("repeat stop x", c2x, 408);
    chk("repeat y", c2y, 232);
    hold(6, 600);
    chk("clamp left", c2x, 0);
    hold(4, 600);
    chk("clamp up", c2y, 0);
    hold(5, 600);
    chk("clamp down", c2y, 464);
    hold(7, 600);
    chk("clamp right", c2x, 624);
    chk("dut2 busy", b2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
